// File: rtl/io_port_bank.sv
// Parametrised CPU I/O port bank: handshaked output registers with sticky overrun,
// double-synchronised inputs with change detection, and registered port reads.
module io_port_bank #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NPORTS = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [WIDTH-1:0]        rd_data,
    output logic [NPORTS*WIDTH-1:0] out_bus,
    output logic [NPORTS-1:0]       out_valid,
    input  logic [NPORTS-1:0]       out_ack,
    output logic [NPORTS-1:0]       ovr,
    input  logic [NPORTS*WIDTH-1:0] in_bus,
    output logic [NPORTS-1:0]       chg
);

    localparam int unsigned BUS_W = NPORTS * WIDTH;

    logic [BUS_W-1:0]  out_q, out_d;
    logic [NPORTS-1:0] valid_q, valid_d;
    logic [NPORTS-1:0] ovr_q, ovr_d;
    logic [NPORTS-1:0] chg_q, chg_d;
    logic [WIDTH-1:0]  rd_data_q, rd_data_d;
    logic [BUS_W-1:0]  s1_q, s2_q, prev_q;
    logic [WIDTH-1:0]  rd_mux;
    logic              wr_sel, rd_sel;

    // Per-port write/handshake, change detection and read select.
    always_comb begin
        out_d     = out_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;
        chg_d     = chg_q;
        rd_data_d = rd_data_q;
        rd_mux    = '0;
        wr_sel    = 1'b0;
        rd_sel    = 1'b0;
        for (int i = 0; i < int'(NPORTS); i++) begin
            wr_sel = we && (wr_addr == ADDR_W'(i));
            rd_sel = rd_en && (rd_addr == ADDR_W'(i));
            if (wr_sel) begin
                out_d[i*WIDTH +: WIDTH] = wr_data;
                valid_d[i]              = 1'b1;
                if (valid_q[i] && !out_ack[i]) begin
                    ovr_d[i] = 1'b1;
                end
            end else if (out_ack[i]) begin
                valid_d[i] = 1'b0;
            end
            if (rd_sel) begin
                chg_d[i] = 1'b0;
                rd_mux   = s2_q[i*WIDTH +: WIDTH];
            end
            // A fresh change on the read edge outranks the read's clear.
            if (s2_q[i*WIDTH +: WIDTH] != prev_q[i*WIDTH +: WIDTH]) begin
                chg_d[i] = 1'b1;
            end
        end
        // Out-of-range addresses match no port, leaving rd_mux at zero.
        if (rd_en) begin
            rd_data_d = rd_mux;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q     <= '0;
            valid_q   <= '0;
            ovr_q     <= '0;
            chg_q     <= '0;
            rd_data_q <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            prev_q    <= '0;
        end else begin
            out_q     <= out_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
            chg_q     <= chg_d;
            rd_data_q <= rd_data_d;
            s1_q      <= in_bus;
            s2_q      <= s1_q;
            prev_q    <= s2_q;
        end
    end

    assign out_bus   = out_q;
    assign out_valid = valid_q;
    assign ovr       = ovr_q;
    assign chg       = chg_q;
    assign rd_data   = rd_data_q;

endmodule
